// File: rtl/pipe_mux_if.sv
// Handshake/data bundle for pipe_mux_reg: N packed WIDTH-bit inputs in, one registered selection out.
// The master drives the inputs and consumes the output; the slave is the mux itself.
interface pipe_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SEL_W = 2
);
  logic [N*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic               freeze;
  logic               flush;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   sel_q;
  logic               err;
  logic [7:0]         err_cnt;

  modport master (
    output in_bus, sel, in_valid, freeze, flush, out_ready,
    input  in_ready, out, out_valid, sel_q, err, err_cnt
  );

  modport slave (
    input  in_bus, sel, in_valid, freeze, flush, out_ready,
    output in_ready, out, out_valid, sel_q, err, err_cnt
  );
endinterface

// File: rtl/pipe_mux_reg.sv
// N-way WIDTH-bit registered pipeline mux with valid/ready, stall and flush.
// Define PIPE_MUX_SEL_CHECK_EN to drop illegal selects and report them on err/err_cnt.
module pipe_mux_reg #(
  parameter int               WIDTH   = 32,
  parameter int               N       = 3,
  parameter int               SEL_W   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  pipe_mux_if.slave  mux_if
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] sel_cap_q, sel_cap_d;
  logic [WIDTH-1:0] mux_data;
  logic             sel_legal;
  logic             in_ready;
  logic             accept;
  logic             capture;
  logic             drain;

  // Out-of-range selects fall back to input 0 so out never goes X.
  always_comb begin
    mux_data  = mux_if.in_bus[WIDTH-1:0];
    sel_legal = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mux_if.sel == SEL_W'(i)) begin
        mux_data  = mux_if.in_bus[i*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
    end
  end

  assign in_ready = !rst && !mux_if.freeze && !mux_if.flush && (!vld_q || mux_if.out_ready);
  assign accept   = mux_if.in_valid && in_ready;

`ifdef PIPE_MUX_SEL_CHECK_EN
  assign capture = accept && sel_legal;
`else
  assign capture = accept;
`endif

  assign drain = vld_q && mux_if.out_ready && !capture;

  always_comb begin
    data_d    = data_q;
    sel_cap_d = sel_cap_q;
    vld_d     = vld_q;
    if (capture) begin
      data_d    = mux_data;
      sel_cap_d = sel_legal ? mux_if.sel : '0;
      vld_d     = 1'b1;
    end else if (drain) begin
      vld_d = 1'b0;
    end
    if (mux_if.flush) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= RST_VAL;
      sel_cap_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      sel_cap_q <= sel_cap_d;
      vld_q     <= vld_d;
    end
  end

`ifdef PIPE_MUX_SEL_CHECK_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       drop;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign drop      = accept && !sel_legal;
  assign err_d     = drop;
  assign err_cnt_d = drop ? sat_inc8(err_cnt_q) : err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign mux_if.err     = err_q;
  assign mux_if.err_cnt = err_cnt_q;
`else
  assign mux_if.err     = 1'b0;
  assign mux_if.err_cnt = 8'h00;
`endif

  assign mux_if.in_ready  = in_ready;
  assign mux_if.out       = data_q;
  assign mux_if.out_valid = vld_q;
  assign mux_if.sel_q     = sel_cap_q;

endmodule
